// File: rtl/memory_dreq_issue.sv
// memory_dreq_issue: issues one data-bus request per memory-stage operation.
// Stores are aligned into byte lanes with a matching write strobe, the bus
// request is held through the address/data handshakes, and the raw read word
// is captured for the load-extraction logic. Misaligned accesses complete
// immediately with AdEL/AdES and never touch the bus.
//
// Bus handshake: dreq_valid is raised on entry to REQ and held, with
// dreq_addr/size/strobe/data stable, up to and including the cycle in which
// dresp_addr_ok is seen. dresp_data_ok completes the transfer, either in that
// same cycle or later while waiting; data_ok before addr_ok is ignored.
module memory_dreq_issue (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_msize,
   input  logic [31:0] req_wdata,
   input  logic        stage_advance,
   output logic        dreq_valid,
   output logic [31:0] dreq_addr,
   output logic [1:0]  dreq_size,
   output logic [3:0]  dreq_strobe,
   output logic [31:0] dreq_data,
   input  logic        dresp_addr_ok,
   input  logic        dresp_data_ok,
   input  logic [31:0] dresp_data,
   output logic [31:0] raw_data,
   output logic        done,
   output logic        stall,
   output logic        adel,
   output logic        ades
);

   // Access size encoding shared with the rest of the core.
   localparam logic [1:0] MSIZE1 = 2'd0;
   localparam logic [1:0] MSIZE2 = 2'd1;
   localparam logic [1:0] MSIZE4 = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic [3:0]  strobe_q, strobe_d;
   logic [31:0] data_q, data_d;
   logic [31:0] raw_q, raw_d;
   logic        adel_q, adel_d;
   logic        ades_q, ades_d;

   logic [1:0]  offset;
   logic        aligned;
   logic [3:0]  lane_strobe;
   logic [31:0] lane_data;

   // Alignment check and store-lane placement for the incoming request.
   always_comb begin
      offset      = req_addr[1:0];
      aligned     = 1'b0;
      lane_strobe = 4'b0000;
      lane_data   = 32'h0;
      case (req_msize)
         MSIZE1: begin
            aligned     = 1'b1;
            lane_strobe = 4'b0001 << offset;
            lane_data   = {4{req_wdata[7:0]}};
         end
         MSIZE2: begin
            aligned     = ~offset[0];
            lane_strobe = 4'b0011 << offset;
            lane_data   = {2{req_wdata[15:0]}};
         end
         MSIZE4: begin
            aligned     = (offset == 2'b00);
            lane_strobe = 4'b1111;
            lane_data   = req_wdata;
         end
         default: begin
            aligned     = 1'b0;
            lane_strobe = 4'b0000;
            lane_data   = 32'h0;
         end
      endcase
      // Loads never write: no lanes enabled and no data driven.
      if (!req_write) begin
         lane_strobe = 4'b0000;
         lane_data   = 32'h0;
      end
   end

   // Next-state and register-update decisions for the request FSM.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      size_d   = size_q;
      strobe_d = strobe_q;
      data_d   = data_q;
      raw_d    = raw_q;
      adel_d   = adel_q;
      ades_d   = ades_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               addr_d   = req_addr;
               size_d   = req_msize;
               strobe_d = lane_strobe;
               data_d   = lane_data;
               if (aligned) begin
                  state_d = S_REQ;
               end else begin
                  // Fault completes at once; no bus traffic, no read data.
                  state_d = S_DONE;
                  adel_d  = ~req_write;
                  ades_d  = req_write;
                  raw_d   = 32'h0;
               end
            end
         end
         S_REQ: begin
            if (dresp_addr_ok && dresp_data_ok) begin
               raw_d   = dresp_data;
               state_d = S_DONE;
            end else if (dresp_addr_ok) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (dresp_data_ok) begin
               raw_d   = dresp_data;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // A request arriving with stage_advance waits for IDLE.
            if (stage_advance) begin
               state_d = S_IDLE;
               adel_d  = 1'b0;
               ades_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and latched-argument registers; reset abandons any transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         addr_q   <= 32'h0;
         size_q   <= 2'b00;
         strobe_q <= 4'b0000;
         data_q   <= 32'h0;
         raw_q    <= 32'h0;
         adel_q   <= 1'b0;
         ades_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         size_q   <= size_d;
         strobe_q <= strobe_d;
         data_q   <= data_d;
         raw_q    <= raw_d;
         adel_q   <= adel_d;
         ades_q   <= ades_d;
      end
   end

   // Outputs decode registered state; only stall looks at req_valid.
   always_comb begin
      dreq_valid  = (state_q == S_REQ);
      dreq_addr   = addr_q;
      dreq_size   = size_q;
      dreq_strobe = strobe_q;
      dreq_data   = data_q;
      raw_data    = raw_q;
      done        = (state_q == S_DONE);
      adel        = adel_q;
      ades        = ades_q;
      stall       = (state_q == S_REQ) || (state_q == S_WAIT) ||
                    ((state_q == S_IDLE) && req_valid);
   end

endmodule

// File: doc/memory_dreq_issue.md
# memory_dreq_issue

Store-side and request-side counterpart to the load-data extraction logic in the memory stage. It takes one memory operation per pipeline slot and aligns store data into byte lanes with a matching write strobe. It then drives the data-bus request and holds it through the address and data handshakes. Finally it captures the raw 32-bit response word, which the load-extraction logic consumes. It also detects misaligned addresses, raises AdEL/AdES without touching the bus, and stalls the pipeline while a transaction is outstanding.

## Interface
- No parameters; widths are fixed.
- Reset is asynchronous and active-high; one clock.
- clk  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  memory stage holds a load or store.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_msize  in  2  MSIZE1 / MSIZE2 / MSIZE4 encoding from mycpu.svh.
- req_wdata  in  32  unshifted store value; the value sits in the low bits.
- stage_advance  in  1  downstream accepts the completed result this cycle.
- dreq_valid  out  1  bus request valid.
- dreq_addr  out  32  latched address.
- dreq_size  out  2  latched msize.
- dreq_strobe  out  4  byte-lane write enables; 0 for loads.
- dreq_data  out  32  lane-replicated store data; 0 for loads.
- dresp_addr_ok  in  1  bus accepted the request.
- dresp_data_ok  in  1  bus data phase complete.
- dresp_data  in  32  raw read word.
- raw_data  out  32  captured read word; valid while done = 1.
- done  out  1  operation complete; result available.
- stall  out  1  freeze upstream stages.
- adel  out  1  load address error; valid with done.
- ades  out  1  store address error; valid with done.

## Operation
- FSM states are IDLE, REQ, WAIT and DONE. Reset forces IDLE asynchronously.
- Reset values: all outputs 0, and all latched registers 0.
- **IDLE**
  - req_valid = 1: latch addr, msize, write, aligned data and strobe.
  - If the address is aligned, go to REQ.
  - If misaligned, go to DONE with adel = ~write or ades = write. No bus request is made and raw_data = 0.
- **Alignment rules**, using offset = addr[1:0]:
  - MSIZE1 is always aligned.
  - MSIZE2 requires offset[0] = 0.
  - MSIZE4 requires offset = 0.
  - Any other msize encoding is treated as misaligned.
- **Store lanes**
  - MSIZE1: strobe = 4'b0001 << offset; data = {4{wdata[7:0]}}.
  - MSIZE2: strobe = 4'b0011 << offset; data = {2{wdata[15:0]}}.
  - MSIZE4: strobe = 4'b1111; data = wdata.
  - Loads: strobe = 0 and data = 0.
- **REQ**
  - dreq_valid = 1 and the dreq_* outputs come from the latch.
  - addr_ok & data_ok in the same cycle: capture dresp_data and go to DONE.
  - addr_ok alone: go to WAIT.
  - Neither: stay in REQ.
  - data_ok without addr_ok is ignored.
- **WAIT**
  - dreq_valid = 0.
  - data_ok: capture dresp_data and go to DONE.
- **DONE**
  - done = 1; raw_data, adel and ades are held.
  - stage_advance: go to IDLE and clear adel, ades and done.
  - A req_valid in that same cycle is not accepted. It is taken in IDLE on the next cycle, costing one bubble.
- **stall** = (state ∈ {REQ, WAIT}) | (state = IDLE & req_valid). It is 0 in DONE.
- **Register update rules**
  - Latched arguments change only on the IDLE → REQ/DONE transition.
  - raw_data changes only on capture.
  - Upstream changes to req_* while in REQ, WAIT or DONE are ignored.

## Timing
- Best case for an aligned access:
  - Cycle 0: req_valid in IDLE.
  - Cycle 1: REQ with dreq_valid = 1, and addr_ok & data_ok both high.
  - Cycle 2: done = 1.
- Misaligned access: req_valid at cycle 0 gives done = 1 with the fault flag at cycle 1.
- dreq_valid stays high continuously from REQ entry until the addr_ok cycle inclusive. dreq_addr, dreq_size, dreq_strobe and dreq_data are stable throughout.
- In WAIT or DONE, dreq_valid is never reasserted for the same operation.
- All outputs are registered state or decode of registered state, with one exception: stall also depends on req_valid.
- Reset asserted mid-transaction (in REQ or WAIT):
  - Return to IDLE immediately and drop dreq_valid asynchronously.
  - A late data_ok after reset is ignored, because the FSM is in IDLE.

## Test plan
- **Byte store:** SB with addr 0x1003, wdata 0x000000A5 → dreq_strobe = 4'b1000, dreq_data = 0xA5A5A5A5, dreq_valid for exactly 1 cycle with addr_ok & data_ok tied high, done on cycle 2, ades = 0.
- **Halfword load with delays:** LH with addr 0x2002; addr_ok after 3 cycles, data_ok 2 cycles later carrying 0xBEEF1234 → strobe = 0; stall high until done; raw_data = 0xBEEF1234; dreq_valid drops on the cycle after addr_ok.
- **Misaligned:** SW at 0x3001 → ades = 1, done at cycle 1, dreq_valid never asserts. LH at 0x3001 → adel = 1.
- **Held done:** done held for 4 cycles with stage_advance = 0 and req_* changing → raw_data and the flags stay constant. stage_advance = 1 with req_valid = 1 → IDLE next cycle, then the new request is latched.
- **Reset mid-transaction:** reset in WAIT → dreq_valid = 0, done = 0, stall = 0 immediately; a subsequent data_ok pulse is ignored.
- **Word store:** SW at 0x4000 with data 0x12345678 → strobe = 4'b1111, data = 0x12345678.
